// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver and its prediction FIFO.
package branch_resolver_pkg;

    localparam int PC_W     = 32;
    localparam int BR_DEPTH = 2;

    typedef struct packed {
        logic            pred;
        logic [PC_W-1:0] target;
        logic [PC_W-1:0] fallthru;
    } bp_entry_t;

endpackage

// File: rtl/br_pred_fifo.sv
// In-flight prediction FIFO: push at tail, pop at head, and a squash that
// pops the head while discarding every younger entry.
module br_pred_fifo
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = BR_DEPTH
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  bp_entry_t push_data_i,
    input  logic      pop_i,
    input  logic      squash_i,
    output logic      full_o,
    output logic      empty_o,
    output bp_entry_t head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        wr_en;
    bp_entry_t   mem_q [DEPTH];

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        wr_en = 1'b0;
        if (squash_i) begin
            // Tail collapses onto head+1, then head is popped: FIFO ends empty.
            rd_d = rd_q + PTR_ONE;
            wr_d = rd_q + PTR_ONE;
        end else begin
            if (pop_i) begin
                rd_d = rd_q + PTR_ONE;
            end
            if (push_i && (!full_o || pop_i)) begin
                wr_en = 1'b1;
                wr_d  = wr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves predicted beq branches in EX: flush/redirect on mispredict,
// registered predictor update, saturating statistics and a sticky error flag.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = BR_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_valid_i,
    input  logic             push_pred_i,
    input  logic [31:0]      push_target_i,
    input  logic [31:0]      push_fallthru_i,
    input  logic             resolve_valid_i,
    input  logic [31:0]      resolve_alu_i,
    output logic             flush_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             upd_valid_o,
    output logic             upd_taken_o,
    output logic [CNT_W-1:0] stat_branches_o,
    output logic [CNT_W-1:0] stat_mispred_o,
    output logic             error_o
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    bp_entry_t        push_data;
    bp_entry_t        head;
    logic             fifo_full, fifo_empty;
    logic             resolve_ok, taken, mispred;
    logic             upd_valid_q, upd_valid_d;
    logic             upd_taken_q, upd_taken_d;
    logic [CNT_W-1:0] branches_q, branches_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;
    logic             error_q, error_d;

    assign push_data = '{pred: push_pred_i, target: push_target_i, fallthru: push_fallthru_i};

    br_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_valid_i),
        .push_data_i (push_data),
        .pop_i       (resolve_ok),
        .squash_i    (mispred),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    always_comb begin
        resolve_ok  = resolve_valid_i && !fifo_empty;
        taken       = (resolve_alu_i == 32'd0);
        mispred     = resolve_ok && (taken ^ head.pred);
        upd_valid_d = resolve_ok;
        upd_taken_d = resolve_ok ? taken : upd_taken_q;
        branches_d  = sat_inc(branches_q, resolve_ok);
        mispred_d   = sat_inc(mispred_q, mispred);
        // A push into a full FIFO is only legal when the head pops this cycle.
        error_d     = error_q
                    | (resolve_valid_i && fifo_empty)
                    | (push_valid_i && fifo_full && !resolve_ok);
    end

    always_comb begin
        flush_o          = mispred;
        redirect_valid_o = mispred;
        redirect_pc_o    = 32'd0;
        if (mispred) begin
            redirect_pc_o = taken ? head.target : head.fallthru;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            upd_valid_q <= 1'b0;
            upd_taken_q <= 1'b0;
            branches_q  <= '0;
            mispred_q   <= '0;
            error_q     <= 1'b0;
        end else begin
            upd_valid_q <= upd_valid_d;
            upd_taken_q <= upd_taken_d;
            branches_q  <= branches_d;
            mispred_q   <= mispred_d;
            error_q     <= error_d;
        end
    end

    assign upd_valid_o     = upd_valid_q;
    assign upd_taken_o     = upd_taken_q;
    assign stat_branches_o = branches_q;
    assign stat_mispred_o  = mispred_q;
    assign error_o         = error_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed plan scenarios followed by
// random traffic compared against a queue-based reference model.
module tb_branch_resolver;

    localparam int DEPTH = 2;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             push_valid_i = 1'b0;
    logic             push_pred_i = 1'b0;
    logic [31:0]      push_target_i = '0;
    logic [31:0]      push_fallthru_i = '0;
    logic             resolve_valid_i = 1'b0;
    logic [31:0]      resolve_alu_i = '0;
    logic             flush_o, redirect_valid_o, upd_valid_o, upd_taken_o, error_o;
    logic [31:0]      redirect_pc_o;
    logic [CNT_W-1:0] stat_branches_o, stat_mispred_o;

    branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .push_valid_i     (push_valid_i),
        .push_pred_i      (push_pred_i),
        .push_target_i    (push_target_i),
        .push_fallthru_i  (push_fallthru_i),
        .resolve_valid_i  (resolve_valid_i),
        .resolve_alu_i    (resolve_alu_i),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .upd_valid_o      (upd_valid_o),
        .upd_taken_o      (upd_taken_o),
        .stat_branches_o  (stat_branches_o),
        .stat_mispred_o   (stat_mispred_o),
        .error_o          (error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit        pred;
        bit [31:0] tgt;
        bit [31:0] ft;
    } ent_t;

    ent_t      q[$];
    int        m_br, m_mp;
    bit        m_err, m_uv, m_ut;
    bit        seen_flush;
    bit [31:0] seen_pc;
    int        n_checks = 0;
    int        n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_br = 0; m_mp = 0; m_err = 0; m_uv = 0; m_ut = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        push_valid_i = 0; resolve_valid_i = 0; resolve_alu_i = '0;
        rst_i = 0;
        #1;
        check("rst_flush", flush_o, 0);
        check("rst_upd_v", upd_valid_o, 0);
        check("rst_upd_t", upd_taken_o, 0);
        check("rst_br", stat_branches_o, 0);
        check("rst_mp", stat_mispred_o, 0);
        check("rst_err", error_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1;
        model_reset();
    endtask

    // One clock: drive at negedge, check combinational outputs, then check
    // registered outputs just after the rising edge against the model.
    task automatic cycle(input bit pv, input bit pp, input bit [31:0] pt, input bit [31:0] pf,
                         input bit rv, input bit [31:0] alu);
        bit rok, tk, mp, full;
        bit [31:0] e_pc;
        @(negedge clk_i);
        push_valid_i = pv; push_pred_i = pp; push_target_i = pt; push_fallthru_i = pf;
        resolve_valid_i = rv; resolve_alu_i = alu;
        #1;
        rok  = rv && (q.size() > 0);
        tk   = (alu == 0);
        mp   = rok && (tk != q[0].pred);
        e_pc = 0;
        if (mp) e_pc = tk ? q[0].tgt : q[0].ft;
        seen_flush = flush_o;
        seen_pc    = redirect_pc_o;
        check("flush", flush_o, mp);
        check("redir_v", redirect_valid_o, mp);
        check("redir_pc", redirect_pc_o, e_pc);
        @(posedge clk_i); #1;
        full = (q.size() == DEPTH);
        if (rv && q.size() == 0) m_err = 1;
        if (pv && full && !rok) m_err = 1;
        m_uv = rok;
        if (rok) begin
            m_ut = tk;
            if (m_br < CMAX) m_br++;
            if (mp && m_mp < CMAX) m_mp++;
            void'(q.pop_front());
        end
        if (mp) q.delete();
        else if (pv && !(full && !rok)) q.push_back('{pp, pt, pf});
        check("upd_v", upd_valid_o, m_uv);
        check("upd_t", upd_taken_o, m_ut);
        check("st_br", stat_branches_o, m_br);
        check("st_mp", stat_mispred_o, m_mp);
        check("err", error_o, m_err);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        do_reset();

        // Correctly predicted taken branch
        cycle(1, 1, 32'h20, 32'h0C, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("t1_flush", seen_flush, 0);
        check("t1_upd_v", upd_valid_o, 1);
        check("t1_upd_t", upd_taken_o, 1);
        check("t1_br", stat_branches_o, 1);
        check("t1_mp", stat_mispred_o, 0);

        // Predict-taken mispredict
        do_reset();
        cycle(1, 1, 32'h20, 32'h0C, 0, 0);
        cycle(0, 0, 0, 0, 1, 5);
        check("t2_flush", seen_flush, 1);
        check("t2_pc", seen_pc, 32'h0C);
        check("t2_upd_t", upd_taken_o, 0);
        check("t2_mp", stat_mispred_o, 1);
        cycle(0, 0, 0, 0, 1, 0);
        check("t2_empty_err", error_o, 1);

        // Predict-not-taken mispredict, flush lasts one cycle
        do_reset();
        cycle(1, 0, 32'h40, 32'h14, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("t3_flush", seen_flush, 1);
        check("t3_pc", seen_pc, 32'h40);
        idle();
        check("t3_flush_off", seen_flush, 0);
        check("t3_upd_v_off", upd_valid_o, 0);

        // Back-to-back: resolve A with B pushed, then B mispredicts
        do_reset();
        cycle(1, 1, 32'h20, 32'h0C, 0, 0);
        cycle(1, 0, 32'h80, 32'h30, 1, 0);
        check("t4_flushA", seen_flush, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("t4_flushB", seen_flush, 1);
        check("t4_pcB", seen_pc, 32'h80);
        check("t4_br", stat_branches_o, 2);
        check("t4_mp", stat_mispred_o, 1);
        check("t4_err", error_o, 0);

        // Squash drops a simultaneous push
        do_reset();
        cycle(1, 1, 32'h20, 32'h0C, 0, 0);
        cycle(1, 1, 32'h60, 32'h24, 1, 7);
        check("t5_flush", seen_flush, 1);
        check("t5_err0", error_o, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("t5_err1", error_o, 1);
        check("t5_br", stat_branches_o, 1);

        // Overflowing push
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 32'h100 + i, 32'h4, 0, 0);
        check("t6_err0", error_o, 0);
        cycle(1, 1, 32'h200, 32'h8, 0, 0);
        check("t6_err1", error_o, 1);

        // Saturation of both counters
        do_reset();
        for (int i = 0; i < CMAX + 2; i++) begin
            cycle(1, 1, 32'h20, 32'h0C, 0, 0);
            cycle(0, 0, 0, 0, 1, 32'h3);
        end
        check("t7_mp_sat", stat_mispred_o, CMAX);
        check("t7_br_sat", stat_branches_o, CMAX);

        // Asynchronous reset mid-cycle with an update pending
        do_reset();
        cycle(1, 1, 32'h20, 32'h0C, 0, 0);
        cycle(1, 1, 32'h50, 32'h10, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("t8_upd_v", upd_valid_o, 1);
        resolve_valid_i = 1; resolve_alu_i = 32'h9;
        #1;
        check("t8_flush_pre", flush_o, 1);
        rst_i = 0;
        #1;
        check("t8_flush", flush_o, 0);
        check("t8_redir_v", redirect_valid_o, 0);
        check("t8_pc", redirect_pc_o, 0);
        check("t8_upd_v0", upd_valid_o, 0);
        check("t8_br", stat_branches_o, 0);
        check("t8_err", error_o, 0);
        resolve_valid_i = 0; resolve_alu_i = '0;
        #1;
        rst_i = 1;
        model_reset();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) do_reset();
            cycle(($urandom % 2) == 1, ($urandom % 2) == 1, $urandom, $urandom,
                  ($urandom % 3) != 0, (($urandom % 2) == 1) ? 32'd0 : $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Closes the loop opposite the 2-bit branch predictor: records each prediction issued for a beq, and resolves it when the branch reaches EX.
- On a mispredict, drives the IF/ID flush and the PC redirect, and returns a taken/not-taken update to the predictor.
- Keeps saturating branch and mispredict statistics for the cycle-trace output.
- Sits between the ID stage (prediction push) and the EX stage (ALU result).

Parameters:
- DEPTH, 2, in-flight prediction entries. Power of two, >=2.
- CNT_W, 16, width of the statistic counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- push_valid_i  in  1  a beq enters ID/EX this cycle. Asserted exactly once per branch, already qualified by stall.
- push_pred_i  in  1  predictor's taken prediction for that branch.
- push_target_i  in  32  branch target PC (ID-computed).
- push_fallthru_i  in  32  PC+4 of the branch.
- resolve_valid_i  in  1  ID_EX branch in EX this cycle.
- resolve_alu_i  in  32  ALU result for the compare. Actual taken = (value == 0).
- flush_o  out  1  flush IF/ID (and bubble ID/EX).
- redirect_valid_o  out  1  load redirect_pc_o into PC.
- redirect_pc_o  out  32  corrected PC.
- upd_valid_o  out  1  predictor update strobe.
- upd_taken_o  out  1  actual outcome for the update.
- stat_branches_o  out  CNT_W  resolved branches.
- stat_mispred_o  out  CNT_W  mispredicted branches.
- error_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_i low, async): FIFO empty, both pointers 0, counters 0, error_o 0, upd_valid_o 0, upd_taken_o 0. flush_o, redirect_valid_o and redirect_pc_o read 0.
- FIFO entry contents: {pred, target, fallthru}. Push writes at tail. Resolve consumes head.
- Resolve takes effect only when resolve_valid_i=1 and the FIFO is non-empty.
  - taken = (resolve_alu_i == 0).
  - mispredict = taken XOR head.pred.
- flush_o, redirect_valid_o and redirect_pc_o are combinational, valid in the same cycle as the resolve.
  - flush_o = redirect_valid_o = mispredict.
  - redirect_pc_o = taken ? head.target : head.fallthru. It is 0 when there is no mispredict.
- Predictor update is registered, one cycle after the resolve.
  - upd_valid_o = 1 for exactly one cycle per valid resolve.
  - upd_taken_o = taken. It holds its value while upd_valid_o=0.
- Counters update at the clock edge ending a valid resolve.
  - stat_branches_o += 1.
  - stat_mispred_o += mispredict.
  - Both saturate at all-ones; no wrap.
- Mispredict squash: all entries younger than head are discarded. After the edge the FIFO is empty (tail := head+1 then popped), so the count becomes 0. A push in the same cycle is also dropped.
- Push and resolve in the same cycle without a mispredict: pop head and push tail. Count is unchanged.
- Resolve with an empty FIFO: error_o := 1. No flush, no update, no counter change.
- Push with a full FIFO and no simultaneous pop: error_o := 1. The push is dropped and the FIFO is unchanged.
- error_o clears only on reset.
- Pointers are log2(DEPTH) bits plus a wrap bit. full = same index with a different wrap bit. empty = equal pointers.
- Reset mid-operation: everything returns to reset values immediately. A pending upd_valid_o is lost.

Decomposition:
- Shared package holds:
  - the bp_entry_t struct {pred, target[31:0], fallthru[31:0]};
  - the BR_DEPTH default;
  - the PC_W=32 constant.
- One natural sub-module: br_pred_fifo. It is a DEPTH-entry FIFO with push, pop, a flush-to-head-pop operation, full/empty flags and a head read port.
- Counters, compare, redirect mux and update register live in the top level.

Test Plan:
- Predicted taken beq correctly taken:
  - Stimulus: push {pred=1, target=0x20, fallthru=0x0C}; next cycle resolve with alu=0.
  - Response: flush_o=0. One cycle later upd_valid_o=1, upd_taken_o=1. Counters read branches=1, mispred=0.
- Predict-taken mispredict:
  - Stimulus: same push, resolve with alu=5.
  - Response: same cycle flush_o=1, redirect_pc_o=0x0C. Next cycle upd_taken_o=0, mispred=1, FIFO empty.
- Predict-not-taken mispredict:
  - Stimulus: push {pred=0, target=0x40, fallthru=0x14}, resolve with alu=0.
  - Response: redirect_pc_o=0x40, flush_o=1 for exactly 1 cycle.
- Back-to-back branches:
  - Stimulus: push A; next cycle push B and resolve A correctly, alu=0 with predA=1; then resolve B mispredicted.
  - Response: count stays 1 across the overlap. B redirects to the correct PC. Final counters read branches=2, mispred=1.
- Squash with simultaneous push:
  - Stimulus: one entry in the FIFO, mispredicting resolve and push in the same cycle.
  - Response: the push is dropped, FIFO empty. A following resolve with no push sets error_o=1.
- Saturation and reset:
  - Stimulus: preload stat_mispred_o to 0xFFFF via 0xFFFF mispredicts (or forced), then one more mispredict.
  - Response: the counter stays at 0xFFFF.
  - Stimulus: drive rst_i low mid-cycle.
  - Response: all outputs return to 0 without waiting for a clock edge.
